tile_map_ctrl: RTL and testbench



---
 rtl/tile_map_ctrl.sv | 153 +++++++++++++++
 tb/tb_tile_map_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_ctrl.sv
// Live 6x8 tile map: loads from the tile ROM on request, serves draw lookups, applies tile clears.
// Latency: load takes ROWS*COLS cycles then pulses load_done; a clear is acked/rejected one cycle after clr_req.
// Backpressure: none; clears outside READY are rejected with clr_err, and draw lookups never stall.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   load_req, level_num            start (or restart) a map load for a level
//   rom_level, rom_x, rom_y        tile ROM address; rom_tile is the combinational ROM data
//   draw_x, draw_y, draw_tile      combinational drawer lookup, 0 when out of range
//   clr_req, clr_x, clr_y          game-logic tile clear; clr_ack / clr_err report the outcome
//   busy, load_done                load in progress / load complete pulse
//   tiles_left, level_clear        non-empty tile count / pulse when the last tile is cleared
module tile_map_ctrl #(
    parameter int COLS    = 8,
    parameter int ROWS    = 6,
    parameter int TYPE_W  = 2,
    parameter int LEVEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    input  logic [LEVEL_W-1:0] level_num,
    output logic [LEVEL_W-1:0] rom_level,
    output logic [2:0]         rom_x,
    output logic [2:0]         rom_y,
    input  logic [TYPE_W-1:0]  rom_tile,
    input  logic [2:0]         draw_x,
    input  logic [2:0]         draw_y,
    output logic [TYPE_W-1:0]  draw_tile,
    input  logic               clr_req,
    input  logic [2:0]         clr_x,
    input  logic [2:0]         clr_y,
    output logic               clr_ack,
    output logic               clr_err,
    output logic               busy,
    output logic               load_done,
    output logic [5:0]         tiles_left,
    output logic               level_clear
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Map is kept flat, row-major: cell = y*COLS + x.
    logic [TYPE_W-1:0]  map_q [CELLS];
    logic [IDX_W-1:0]   idx;
    logic [LEVEL_W-1:0] level_q;
    logic [5:0]         cnt;

    logic               load_last;
    logic               draw_ok;
    logic [IDX_W-1:0]   draw_idx;
    logic               clr_in_range;
    logic [IDX_W-1:0]   clr_idx;
    logic [TYPE_W-1:0]  clr_tile;
    logic               clr_ok;
    logic               clr_bad;

    // ROM address is just the load index split into row/column.
    assign rom_x      = 3'(32'(idx) % COLS);
    assign rom_y      = 3'(32'(idx) / COLS);
    assign rom_level  = level_q;
    assign busy       = (state == LOAD);
    assign tiles_left = cnt;

    // Draw lookup is a plain read of the register map.
    assign draw_ok   = (32'(draw_x) < COLS) && (32'(draw_y) < ROWS);
    assign draw_idx  = IDX_W'(32'(draw_y) * COLS + 32'(draw_x));
    assign draw_tile = draw_ok ? map_q[draw_idx] : '0;

    assign clr_in_range = (32'(clr_x) < COLS) && (32'(clr_y) < ROWS);
    assign clr_idx      = IDX_W'(32'(clr_y) * COLS + 32'(clr_x));
    assign clr_tile     = clr_in_range ? map_q[clr_idx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_last = 1'b0;
        clr_ok    = 1'b0;
        clr_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) state_nxt = LOAD;
            end
            LOAD: begin
                load_last = (32'(idx) == CELLS - 1);
                if (load_req)       state_nxt = LOAD;
                else if (load_last) state_nxt = READY;
            end
            READY: begin
                if (load_req) state_nxt = LOAD;
                // A load in the same cycle takes priority over the clear.
                clr_ok = clr_req && !load_req && clr_in_range && (clr_tile != '0);
            end
            default: state_nxt = IDLE;
        endcase
        clr_bad = clr_req && !clr_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) map_q[i] <= '0;
            idx         <= '0;
            level_q     <= '0;
            cnt         <= '0;
            clr_ack     <= 1'b0;
            clr_err     <= 1'b0;
            load_done   <= 1'b0;
            level_clear <= 1'b0;
        end else begin
            clr_ack     <= 1'b0;
            load_done   <= 1'b0;
            level_clear <= 1'b0;
            clr_err     <= clr_bad;
            if (load_req) begin
                // Restart: the cell addressed this cycle is not captured.
                level_q <= level_num;
                idx     <= '0;
                cnt     <= '0;
            end else if (state == LOAD) begin
                map_q[idx] <= rom_tile;
                cnt        <= cnt + 6'(rom_tile != '0);
                if (load_last) begin
                    idx       <= '0;
                    load_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if (clr_ok) begin
                map_q[clr_idx] <= '0;
                cnt            <= cnt - 6'd1;
                clr_ack        <= 1'b1;
                level_clear    <= (cnt == 6'd1);
            end
        end
    end

endmodule

// File: tb/tb_tile_map_ctrl.sv
module tb_tile_map_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic [1:0] level_num;
    logic [1:0] rom_level;
    logic [2:0] rom_x, rom_y;
    logic [1:0] rom_tile;
    logic [2:0] draw_x, draw_y;
    logic [1:0] draw_tile;
    logic       clr_req;
    logic [2:0] clr_x, clr_y;
    logic       clr_ack, clr_err, busy, load_done, level_clear;
    logic [5:0] tiles_left;

    int checks = 0;
    int errors = 0;

    // Behavioural ROM contents and expected map, flat row-major (y*8+x).
    logic [1:0] rom_mem [4][48];
    logic [1:0] exp_map [48];
    int         exp_left;

    always #5 clk = ~clk;

    assign rom_tile = rom_mem[rom_level][int'(rom_y) * 8 + int'(rom_x)];

    tile_map_ctrl dut (
        .clk(clk), .reset(reset), .load_req(load_req), .level_num(level_num),
        .rom_level(rom_level), .rom_x(rom_x), .rom_y(rom_y), .rom_tile(rom_tile),
        .draw_x(draw_x), .draw_y(draw_y), .draw_tile(draw_tile),
        .clr_req(clr_req), .clr_x(clr_x), .clr_y(clr_y),
        .clr_ack(clr_ack), .clr_err(clr_err), .busy(busy), .load_done(load_done),
        .tiles_left(tiles_left), .level_clear(level_clear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_tiles(input int lvl);
        int n = 0;
        for (int i = 0; i < 48; i++) if (rom_mem[lvl][i] != 2'd0) n++;
        return n;
    endfunction

    task automatic init_rom();
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 48; i++) rom_mem[l][i] = 2'd0;
        // Level 0: 11 hand-placed tiles, (2,4)=1 and (7,5)=0.
        rom_mem[0][0*8+0] = 2'd1; rom_mem[0][0*8+1] = 2'd2; rom_mem[0][0*8+7] = 2'd3;
        rom_mem[0][1*8+3] = 2'd1; rom_mem[0][1*8+6] = 2'd1; rom_mem[0][2*8+4] = 2'd2;
        rom_mem[0][3*8+5] = 2'd3; rom_mem[0][4*8+2] = 2'd1; rom_mem[0][4*8+6] = 2'd2;
        rom_mem[0][5*8+0] = 2'd2; rom_mem[0][5*8+3] = 2'd1;
        // Levels 1 and 2 random, level 3 stays empty.
        for (int l = 1; l < 3; l++)
            for (int i = 0; i < 48; i++) rom_mem[l][i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 48; i++) exp_map[i] = 2'd0;
        exp_left = 0;
    endtask

    // Full load: busy for 48 cycles, then a single load_done pulse.
    task automatic do_load(input int lvl);
        int n = 0;
        level_num = 2'(lvl);
        load_req  = 1'b1;
        step();
        load_req  = 1'b0;
        while (busy && n < 100) begin
            n++;
            checks++;
            if (load_done !== 1'b0 || level_clear !== 1'b0) begin
                errors++;
                $display("FAIL load_pulse_early lvl=%0d cyc=%0d: load_done=%b level_clear=%b, required 0", lvl, n, load_done, level_clear);
            end
            step();
        end
        checks++;
        if (n != 48 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL load_len lvl=%0d: busy cycles=%0d load_done=%b, required 48 and 1", lvl, n, load_done);
        end
        for (int i = 0; i < 48; i++) exp_map[i] = rom_mem[lvl][i];
        exp_left = count_tiles(lvl);
        checks++;
        if (tiles_left !== 6'(exp_left) || level_clear !== 1'b0) begin
            errors++;
            $display("FAIL load_count lvl=%0d: tiles_left=%0d level_clear=%b, required %0d and 0", lvl, tiles_left, level_clear, exp_left);
        end
        step();
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse lvl=%0d: load_done=%b, required 0", lvl, load_done);
        end
    endtask

    // One clear request in READY, checked against the expected map.
    task automatic do_clear(input int x, input int y);
        bit valid = (y < 6) && (exp_map[(y < 6) ? y * 8 + x : 0] != 2'd0);
        bit last  = valid && (exp_left == 1);
        clr_x = 3'(x); clr_y = 3'(y); clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        if (valid) begin
            exp_map[y * 8 + x] = 2'd0;
            exp_left--;
        end
        checks++;
        if (clr_ack !== valid || clr_err !== !valid || level_clear !== last || tiles_left !== 6'(exp_left)) begin
            errors++;
            $display("FAIL clear(%0d,%0d): ack=%b err=%b lc=%b left=%0d, required %b %b %b %0d",
                     x, y, clr_ack, clr_err, level_clear, tiles_left, valid, !valid, last, exp_left);
        end
        draw_x = 3'(x); draw_y = 3'(y);
        #1;
        checks++;
        if (draw_tile !== ((y < 6) ? exp_map[y * 8 + x] : 2'd0)) begin
            errors++;
            $display("FAIL clear_draw(%0d,%0d): draw_tile=%0d, required %0d", x, y, draw_tile, (y < 6) ? exp_map[y * 8 + x] : 2'd0);
        end
        step();
    endtask

    task automatic check_map(input string tag);
        int bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                draw_x = 3'(x); draw_y = 3'(y);
                #1;
                if (draw_tile !== ((y < 6) ? exp_map[y * 8 + x] : 2'd0)) bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL map_%s: %0d cells differ, required 0", tag, bad);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || tiles_left !== 6'd0 || rom_x !== 3'd0 || rom_y !== 3'd0 || rom_level !== 2'd0 ||
            clr_ack !== 1'b0 || clr_err !== 1'b0 || load_done !== 1'b0 || level_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b left=%0d rom=%0d/%0d/%0d pulses=%b%b%b%b, required all 0",
                     busy, tiles_left, rom_level, rom_x, rom_y, clr_ack, clr_err, load_done, level_clear);
        end
        check_map("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        // Clear before any load is rejected.
        do_clear(2, 4);
    endtask

    task automatic test_load_level0();
        do_load(0);
        draw_x = 3'd2; draw_y = 3'd4; #1;
        checks++;
        if (draw_tile !== 2'd1) begin
            errors++;
            $display("FAIL draw_2_4: draw_tile=%0d, required 1", draw_tile);
        end
        draw_x = 3'd7; draw_y = 3'd5; #1;
        checks++;
        if (draw_tile !== 2'd0) begin
            errors++;
            $display("FAIL draw_7_5: draw_tile=%0d, required 0", draw_tile);
        end
        step();
        check_map("level0");
    endtask

    task automatic test_clear_basic();
        do_clear(2, 4);
        do_clear(2, 4);
        do_clear(3, 6);
        do_clear(7, 7);
        check_map("after_bad_clears");
    endtask

    task automatic test_clear_all();
        int lc = 0;
        for (int i = 0; i < 48; i++)
            if (exp_map[i] != 2'd0) do_clear(i % 8, i / 8);
        checks++;
        if (tiles_left !== 6'd0) begin
            errors++;
            $display("FAIL clear_all_left: tiles_left=%0d, required 0", tiles_left);
        end
        // Further clears are rejected and never re-pulse level_clear.
        for (int k = 0; k < 3; k++) begin
            clr_x = 3'($urandom_range(0, 7)); clr_y = 3'($urandom_range(0, 5)); clr_req = 1'b1;
            step();
            clr_req = 1'b0;
            if (level_clear) lc++;
        end
        checks++;
        if (lc != 0 || clr_err !== 1'b1) begin
            errors++;
            $display("FAIL clear_empty: level_clear count=%0d clr_err=%b, required 0 and 1", lc, clr_err);
        end
        step();
    endtask

    task automatic test_random_clears();
        do_load(1);
        check_map("level1");
        for (int k = 0; k < 40; k++) do_clear($urandom_range(0, 7), $urandom_range(0, 7));
        check_map("level1_cleared");
    endtask

    task automatic test_load_abort();
        int n = 0;
        int dones = 0;
        level_num = 2'd2; load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (20) step();
        // 20 cells written: cell 5 is new, cell 40 still holds the previous map.
        draw_x = 3'd5; draw_y = 3'd0; #1;
        checks++;
        if (draw_tile !== rom_mem[2][5]) begin
            errors++;
            $display("FAIL partial_new: draw_tile=%0d, required %0d", draw_tile, rom_mem[2][5]);
        end
        draw_x = 3'd0; draw_y = 3'd5; #1;
        checks++;
        if (draw_tile !== exp_map[40]) begin
            errors++;
            $display("FAIL partial_old: draw_tile=%0d, required %0d", draw_tile, exp_map[40]);
        end
        // Restart with level 1 together with a clear: load wins.
        level_num = 2'd1; load_req = 1'b1; clr_req = 1'b1; clr_x = 3'd0; clr_y = 3'd0;
        step();
        load_req = 1'b0;
        checks++;
        if (clr_err !== 1'b1 || busy !== 1'b1 || rom_level !== 2'd1 || rom_x !== 3'd0 || rom_y !== 3'd0) begin
            errors++;
            $display("FAIL restart: err=%b busy=%b rom=%0d/%0d/%0d, required 1 1 1/0/0", clr_err, busy, rom_level, rom_x, rom_y);
        end
        n = 1;
        step();
        clr_req = 1'b0;
        n = 2;
        checks++;
        if (clr_err !== 1'b1 || clr_ack !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_load: err=%b ack=%b, required 1 0", clr_err, clr_ack);
        end
        while (busy && n < 100) begin
            if (load_done) dones++;
            step();
            if (busy) n++;
        end
        if (load_done) dones++;
        checks++;
        if (n != 48 || dones != 1) begin
            errors++;
            $display("FAIL abort_len: busy cycles=%0d load_done pulses=%0d, required 48 and 1", n, dones);
        end
        for (int i = 0; i < 48; i++) exp_map[i] = rom_mem[1][i];
        exp_left = count_tiles(1);
        checks++;
        if (tiles_left !== 6'(exp_left)) begin
            errors++;
            $display("FAIL abort_count: tiles_left=%0d, required %0d", tiles_left, exp_left);
        end
        step();
        check_map("after_abort");
    endtask

    task automatic test_empty_level();
        do_load(3);
        do_clear(1, 1);
    endtask

    task automatic test_reset_mid_load();
        int bad = 0;
        level_num = 2'd2; load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || tiles_left !== 6'd0 || rom_x !== 3'd0 || rom_y !== 3'd0 || rom_level !== 2'd0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: busy=%b left=%0d rom=%0d/%0d/%0d done=%b, required all 0",
                     busy, tiles_left, rom_level, rom_x, rom_y, load_done);
        end
        for (int i = 0; i < 64; i++) begin
            draw_x = 3'(i % 8); draw_y = 3'(i / 8);
            #0.1;
            if (draw_tile !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_draw: %0d cells nonzero, required 0", bad);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 48; i++) exp_map[i] = 2'd0;
        exp_left = 0;
        step();
        do_load(0);
    endtask

    initial begin
        reset = 1'b1; load_req = 1'b0; level_num = 2'd0; clr_req = 1'b0;
        clr_x = 3'd0; clr_y = 3'd0; draw_x = 3'd0; draw_y = 3'd0;
        init_rom();
        test_reset();
        test_load_level0();
        test_clear_basic();
        test_clear_all();
        test_random_clears();
        test_load_abort();
        test_empty_level();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
